clock_enable_gen: RTL and testbench

Parametrised successor to the fixed system frequency generator. It divides `clock_in` by a prescaler to form a base tick, then feeds `N_CH` independently programmable divider channels. Each channel produces a square wave and a one-cycle enable strobe. Divisors can be rewritten at run time and take effect glitch-free at the channel's period boundary. The block sits at the top level and supplies CPU, console, timer and peripheral clocks and enables.

---
 rtl/clock_enable_gen.sv | 84 ++++++++
 tb/tb_clock_enable_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/clock_enable_gen.sv
// clock_enable_gen: prescaled base tick feeding N_CH programmable divider channels with tick and square-wave outputs
// Optional: define CLKGEN_SYNC_EN to add sync_req, which forces every channel to wrap on the next base tick.
module clock_enable_gen #(
  parameter int PRE_DIV = 5,
  parameter int N_CH    = 4,
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 2,
  parameter int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             div_wr,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [DIV_W-1:0] div_data,
`ifdef CLKGEN_SYNC_EN
  input  logic             sync_req,
`endif
  output logic [N_CH-1:0]  div_busy,
  output logic             base_tick,
  output logic [N_CH-1:0]  ch_tick,
  output logic [N_CH-1:0]  ch_clk
);
  localparam int PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);
  localparam logic [DIV_W-1:0] D_RST = DIV_W'(DIV_RST);
  localparam logic [DIV_W-1:0] C_RST = (DIV_RST == 0) ? '0 : DIV_W'(DIV_RST - 1);
  logic [PW-1:0] pre_cnt;
  logic sync_go;
  always_ff @(posedge clock_in) begin
    if (reset) begin
      pre_cnt   <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= pre_cnt == PRE_LAST;
      pre_cnt   <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
    end
  end
`ifdef CLKGEN_SYNC_EN
  logic sync_q;
  // a request arriving on a base-tick edge survives the clear and acts on the next tick
  always_ff @(posedge clock_in) begin
    if (reset) sync_q <= 1'b0;
    else       sync_q <= sync_req | (sync_q & ~base_tick);
  end
  assign sync_go = sync_q;
`else
  assign sync_go = 1'b0;
`endif
  for (genvar g = 0; g < N_CH; g++) begin : ch
    logic [DIV_W-1:0] d, c, p, nd, nc;
    logic [DIV_W:0] half;
    logic busy, tick, sq, hit, wrap, restart;
    always_comb begin
      hit     = div_wr && (div_sel == SEL_W'(g));
      wrap    = ((d != '0) && (c == d - 1'b1)) || sync_go;
      restart = wrap || (busy && (d == '0));
      nd      = (restart && busy) ? p : d;
      nc      = (restart || (d == '0)) ? '0 : c + 1'b1;
      half    = ({1'b0, nd} + 1'b1) >> 1;
    end
    always_ff @(posedge clock_in) begin
      if (reset) begin
        d    <= D_RST;
        c    <= C_RST;
        p    <= '0;
        busy <= 1'b0;
        tick <= 1'b0;
        sq   <= 1'b0;
      end else begin
        tick <= base_tick && restart && (nd != '0);
        if (base_tick) begin
          d  <= nd;
          c  <= nc;
          sq <= (nd != '0) && ({1'b0, nc} < half);
        end
        if (hit) p <= div_data;
        busy <= hit || (busy && !(base_tick && restart));
      end
    end
    assign div_busy[g] = busy;
    assign ch_tick[g]  = tick;
    assign ch_clk[g]   = sq;
  end
endmodule

// File: tb/tb_clock_enable_gen.sv
// tb_clock_enable_gen: directed checks of prescaler, divider channels, reprogramming, stop/restart and reset
module tb_clock_enable_gen;
  logic clock_in, reset, div_wr;
  logic [1:0] div_sel;
  logic [7:0] div_data;
  logic [3:0] div_busy, ch_tick, ch_clk;
  logic base_tick;
  logic [2:0] busy3, tick3, clk3;
  logic bt3;
  int n_cmp, n_err, ed;

  clock_enable_gen #(.PRE_DIV(5), .N_CH(4), .DIV_W(8), .DIV_RST(2)) dut (
    .clock_in(clock_in), .reset(reset), .div_wr(div_wr), .div_sel(div_sel), .div_data(div_data),
    .div_busy(div_busy), .base_tick(base_tick), .ch_tick(ch_tick), .ch_clk(ch_clk));

  clock_enable_gen #(.PRE_DIV(5), .N_CH(3), .DIV_W(8), .DIV_RST(2)) dut3 (
    .clock_in(clock_in), .reset(reset), .div_wr(div_wr), .div_sel(div_sel), .div_data(div_data),
    .div_busy(busy3), .base_tick(bt3), .ch_tick(tick3), .ch_clk(clk3));

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, ed, got, exp);
    end
  endtask

  task automatic goto(input int e);
    while (ed < e) begin
      @(posedge clock_in);
      ed++;
    end
    #1;
  endtask

  task automatic wr(input int e, input int s, input int d);
    goto(e - 1);
    div_wr = 1'b1;
    div_sel = 2'(s);
    div_data = 8'(d);
    goto(e);
    div_wr = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; ed = 0;
    reset = 1'b1; div_wr = 1'b0; div_sel = '0; div_data = '0;
    repeat (2) @(posedge clock_in);
    #1;
    chk("rst_base", 32'(base_tick), 0);
    chk("rst_tick", 32'(ch_tick), 0);
    chk("rst_clk", 32'(ch_clk), 0);
    chk("rst_busy", 32'(div_busy), 0);
    reset = 1'b0;
    goto(4);  chk("base_e4", 32'(base_tick), 0);
    goto(5);  chk("base_e5", 32'(base_tick), 1);
    goto(6);  chk("base_e6", 32'(base_tick), 0);
              chk("tick_e6", 32'(ch_tick), 4'hf);
              chk("clk_e6", 32'(ch_clk), 4'hf);
    goto(7);  chk("tick_e7", 32'(ch_tick), 0);
              chk("clk_e7", 32'(ch_clk), 4'hf);
    wr(8, 1, 16); chk("busy_wr1", 32'(div_busy), 4'b0010);
    goto(11); chk("clk_low_e11", 32'(ch_clk), 0);
    goto(15); chk("busy_hold1", 32'(div_busy), 4'b0010);
    goto(16); chk("busy_apply1", 32'(div_busy), 0);
              chk("tick_e16", 32'(ch_tick), 4'hf);
              chk("clk_e16", 32'(ch_clk), 4'hf);
    wr(18, 0, 3); chk("busy_wr0", 32'(div_busy), 4'b0001);
    goto(25); chk("busy_hold0", 32'(div_busy), 4'b0001);
    goto(26); chk("busy_apply0", 32'(div_busy), 0);
              chk("tick_e26", 32'(ch_tick), 4'b1101);
    goto(35); chk("odd_clk_hi", 32'(ch_clk[0]), 1);
    goto(36); chk("odd_clk_lo", 32'(ch_clk[0]), 0);
    goto(40); chk("odd_tick_pre", 32'(ch_tick[0]), 0);
    goto(41); chk("odd_tick", 32'(ch_tick[0]), 1);
              chk("odd_clk_rise", 32'(ch_clk[0]), 1);
    wr(43, 2, 0);
    goto(46); chk("stop_tick", 32'(ch_tick), 4'b1000);
              chk("stop_clk", 32'(ch_clk), 4'b1011);
              chk("stop_busy", 32'(div_busy), 0);
    goto(55); chk("d16_clk_hi", 32'(ch_clk[1]), 1);
    goto(56); chk("d16_clk_lo", 32'(ch_clk[1]), 0);
              chk("tick_e56", 32'(ch_tick), 4'b1001);
    wr(58, 2, 4);
    goto(60); chk("restart_pre_clk", 32'(ch_clk[2]), 0);
              chk("restart_busy", 32'(div_busy), 4'b0100);
    goto(61); chk("restart_tick", 32'(ch_tick[2]), 1);
              chk("restart_clk", 32'(ch_clk[2]), 1);
              chk("restart_busy_clr", 32'(div_busy), 0);
    goto(71); chk("d4_clk_lo", 32'(ch_clk[2]), 0);
    goto(81); chk("d4_tick", 32'(ch_tick[2]), 1);
    wr(82, 3, 7);
    wr(83, 3, 9); chk("ovw_busy", 32'(div_busy[3]), 1);
    goto(86); chk("ovw_apply_busy", 32'(div_busy[3]), 0);
              chk("ovw_apply_tick", 32'(ch_tick[3]), 1);
    goto(95); chk("d16_tick_pre", 32'(ch_tick[1]), 0);
    goto(96); chk("d16_tick", 32'(ch_tick[1]), 1);
              chk("d16_clk_rise", 32'(ch_clk[1]), 1);
    wr(100, 2, 5);
    wr(101, 2, 6);
              chk("same_edge_busy", 32'(div_busy[2]), 1);
              chk("same_edge_tick", 32'(ch_tick[2]), 1);
    goto(121); chk("d9_not_d7", 32'(ch_tick[3]), 0);
    goto(126); chk("d5_tick", 32'(ch_tick[2]), 1);
               chk("d6_applied_busy", 32'(div_busy[2]), 0);
               chk("d9_tick_pre", 32'(ch_tick[3]), 0);
    goto(131); chk("d9_tick", 32'(ch_tick[3]), 1);
    wr(141, 3, 1);
               chk("ign_sel3_busy", 32'(busy3), 0);
               chk("sel3_busy_4ch", 32'(div_busy), 4'b1000);
    wr(150, 1, 20);
               chk("busy_pre_rst", 32'(div_busy), 4'b1010);
    goto(151);
    reset = 1'b1;
    goto(152);
    chk("mrst_base", 32'(base_tick), 0);
    chk("mrst_tick", 32'(ch_tick), 0);
    chk("mrst_clk", 32'(ch_clk), 0);
    chk("mrst_busy", 32'(div_busy), 0);
    chk("mrst_busy3", 32'(busy3), 0);
    reset = 1'b0;
    ed = 0;
    goto(4);  chk("re_base_e4", 32'(base_tick), 0);
    goto(5);  chk("re_base_e5", 32'(base_tick), 1);
    goto(6);  chk("re_tick_e6", 32'(ch_tick), 4'hf);
              chk("re_clk_e6", 32'(ch_clk), 4'hf);
              chk("re_busy_e6", 32'(div_busy), 0);
    goto(11); chk("re_clk_e11", 32'(ch_clk), 0);
    goto(16); chk("re_tick_e16", 32'(ch_tick), 4'hf);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
